// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the serial joystick readers.
package joy_serial_pkg;

    // Width of one published player word
    localparam int unsigned JOY_WORD_W = 16;

    // Button positions inside a player word, layout "LS FEDCBAUDLR" (shared with joy_db9md)
    localparam int unsigned JOY_BIT_RIGHT = 0;
    localparam int unsigned JOY_BIT_LEFT  = 1;
    localparam int unsigned JOY_BIT_DOWN  = 2;
    localparam int unsigned JOY_BIT_UP    = 3;
    localparam int unsigned JOY_BIT_A     = 4;
    localparam int unsigned JOY_BIT_B     = 5;
    localparam int unsigned JOY_BIT_C     = 6;
    localparam int unsigned JOY_BIT_D     = 7;
    localparam int unsigned JOY_BIT_E     = 8;
    localparam int unsigned JOY_BIT_F     = 9;
    localparam int unsigned JOY_BIT_START = 10;
    localparam int unsigned JOY_BIT_L     = 11;

    // Scan sequencer states
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SAMPLE,
        CLK_LO,
        CLK_HI,
        COMMIT,
        GAP
    } joy_state_t;

endpackage

// File: rtl/joy_tick_gen.sv
// Divides clk into a one-cycle tick every CLK_DIV cycles while run is high.
module joy_tick_gen #(
    parameter int unsigned CLK_DIV = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;

    // Free-running divider, parked at zero whenever run is low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = run && (r_cnt == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/joy_serial_multi.sv
// Serial multi-player joystick reader: drives adapter clock/load, shifts in
// PLAYERS*BITS bits per frame and publishes debounced per-player words.
module joy_serial_multi
    import joy_serial_pkg::*;
#(
    parameter int unsigned PLAYERS   = 2,
    parameter int unsigned BITS      = 12,
    parameter int unsigned CLK_DIV   = 32,
    parameter int unsigned FRAME_GAP = 64,
    parameter int unsigned DEBOUNCE  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          joy_data,
    output logic                          joy_clk,
    output logic                          joy_load,
    output logic [PLAYERS*JOY_WORD_W-1:0] joystick,
    output logic                          frame_done,
    output logic                          update
);

    localparam int unsigned N_BITS = PLAYERS * BITS;
    localparam int unsigned JW     = PLAYERS * JOY_WORD_W;
    localparam int unsigned IDX_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int unsigned DCNT_W = $clog2(DEBOUNCE + 1);

    joy_state_t        r_state;
    joy_state_t        w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic [N_BITS-1:0] r_shift;
    logic [JW-1:0]     r_cand;
    logic [JW-1:0]     r_joystick;
    logic [DCNT_W-1:0] r_cnt;
    logic              r_joy_clk;
    logic              r_joy_load;
    logic              r_frame_done;
    logic              r_update;

    logic [JW-1:0]     w_frame;
    logic [DCNT_W-1:0] w_cnt_nxt;
    logic              w_run;
    logic              w_tick;
    logic              w_sample;
    logic              w_idx_inc;
    logic              w_idx_clr;
    logic              w_gap_inc;
    logic              w_gap_clr;
    logic              w_commit;
    logic              w_commit_upd;
    logic              w_joy_clk_nxt;
    logic              w_joy_load_nxt;

    // Divider is held only while parked in IDLE and during the single-cycle COMMIT
    assign w_run = !((r_state == IDLE) && !enable) && (r_state != COMMIT);

    joy_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_run),
        .tick    (w_tick)
    );

    // Spread the packed serial frame into 16-bit player words, upper bits zero
    for (genvar p = 0; p < PLAYERS; p++) begin : g_word
        assign w_frame[p*JOY_WORD_W +: JOY_WORD_W] = JOY_WORD_W'(r_shift[p*BITS +: BITS]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath strobes and next line levels
    always_comb begin
        w_state_nxt    = r_state;
        w_sample       = 1'b0;
        w_idx_inc      = 1'b0;
        w_idx_clr      = 1'b0;
        w_gap_inc      = 1'b0;
        w_gap_clr      = 1'b0;
        w_commit       = 1'b0;
        w_joy_clk_nxt  = 1'b1;
        w_joy_load_nxt = 1'b1;

        case (r_state)
            IDLE: begin
                if (w_tick && enable) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (w_tick) begin
                    if (!enable) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SAMPLE;
                        w_idx_clr   = 1'b1;
                    end
                end
            end
            SAMPLE: begin
                if (w_tick) begin
                    if (!enable) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = CLK_LO;
                        w_sample    = 1'b1;
                    end
                end
            end
            CLK_LO: begin
                if (w_tick) begin
                    w_state_nxt = enable ? CLK_HI : IDLE;
                end
            end
            CLK_HI: begin
                if (w_tick) begin
                    if (!enable) begin
                        w_state_nxt = IDLE;
                    end else if (r_idx < IDX_W'(N_BITS - 1)) begin
                        w_state_nxt = SAMPLE;
                        w_idx_inc   = 1'b1;
                    end else begin
                        w_state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_gap_clr   = 1'b1;
                w_state_nxt = GAP;
            end
            GAP: begin
                if (w_tick) begin
                    if (r_gap == GAP_W'(FRAME_GAP - 1)) begin
                        w_state_nxt = enable ? LOAD : IDLE;
                    end else begin
                        w_gap_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_state_nxt == CLK_LO) begin
            w_joy_clk_nxt = 1'b0;
        end
        if (w_state_nxt == LOAD) begin
            w_joy_load_nxt = 1'b0;
        end
    end

    // Debounce step: count identical consecutive frames, commit once enough agree
    always_comb begin
        w_cnt_nxt = DCNT_W'(1);
        if (w_frame == r_cand) begin
            w_cnt_nxt = (r_cnt == DCNT_W'(DEBOUNCE)) ? r_cnt : r_cnt + DCNT_W'(1);
        end
        w_commit_upd = w_commit && (w_cnt_nxt >= DCNT_W'(DEBOUNCE)) && (w_frame != r_joystick);
    end

    // Shift register, counters, debounce state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_gap        <= '0;
            r_shift      <= '0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_joystick   <= '0;
            r_joy_clk    <= 1'b1;
            r_joy_load   <= 1'b1;
            r_frame_done <= 1'b0;
            r_update     <= 1'b0;
        end else begin
            r_joy_clk    <= w_joy_clk_nxt;
            r_joy_load   <= w_joy_load_nxt;
            r_frame_done <= w_commit;
            r_update     <= w_commit_upd;

            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (w_gap_clr) begin
                r_gap <= '0;
            end else if (w_gap_inc) begin
                r_gap <= r_gap + GAP_W'(1);
            end

            if (w_sample) begin
                r_shift[r_idx] <= ~joy_data;
            end

            if (w_commit) begin
                r_cand <= w_frame;
                r_cnt  <= w_cnt_nxt;
            end

            if (w_commit_upd) begin
                r_joystick <= w_frame;
            end
        end
    end

    assign joy_clk    = r_joy_clk;
    assign joy_load   = r_joy_load;
    assign joystick   = r_joystick;
    assign frame_done = r_frame_done;
    assign update     = r_update;

endmodule
